case_invert_echo: RTL

//   Buffered echo stage between the UART receiver and the UART transmitter

---
 rtl/case_invert_echo_pkg.sv | 25 ++
 rtl/case_invert_echo_sync_fifo.sv | 61 ++++++
 rtl/case_invert_echo.sv | 57 +++++
 3 files changed

// File: rtl/case_invert_echo_pkg.sv
// Shared ASCII constants and the case-swap transform used by the echo stage.
// The constant names match the ones the UART case checker uses.
package case_invert_echo_pkg;

  localparam logic [7:0] ASCII_UC_A     = 8'h41;
  localparam logic [7:0] ASCII_UC_Z     = 8'h5A;
  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'd32;

  // Only the 52 letter codes move; every other byte passes through untouched.
  function automatic logic [7:0] xform(input logic [7:0] b, input logic bypass);
    logic [7:0] res;
    res = b;
    if (!bypass) begin
      if (b >= ASCII_UC_A && b <= ASCII_UC_Z) begin
        res = b + ASCII_CASE_OFS;
      end else if (b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
        res = b - ASCII_CASE_OFS;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/case_invert_echo_sync_fifo.sv
// Single-clock ready/valid FIFO. Outputs are driven only from registered state,
// so there is no combinational path from push/pop inputs to any output.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign push_ready = (r_count != (AW+1)'(DEPTH));
  assign pop_valid  = (r_count != '0);
  assign pop_data   = r_mem[r_rd_ptr];
  assign count      = r_count;

  assign w_push = push_valid & push_ready;
  assign w_pop  = pop_valid & pop_ready;

  // NOTE: the storage array has no reset; count gates every read, so stale
  // entries are never observed and the array can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/case_invert_echo.sv
// Echo stage between UART RX and TX: swaps ASCII letter case (unless bypassed)
// at enqueue time and buffers bytes so the transmitter can lag behind bursts.
module case_invert_echo
  import case_invert_echo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bypass,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [7:0]  data_out,
  output logic        data_out_valid,
  input  logic        data_out_ready,
  output logic [AW:0] count,
  output logic        overflow
);

  logic [7:0] w_xformed;
  logic       w_in_ready;
  logic       r_overflow;

  // NOTE: combinational logic assigns its result unconditionally inside the
  // function, so no path leaves it unassigned and no latch is inferred.
  assign w_xformed = xform(data_in, bypass);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_data  (w_xformed),
    .push_valid (data_in_valid),
    .push_ready (w_in_ready),
    .pop_data   (data_out),
    .pop_valid  (data_out_valid),
    .pop_ready  (data_out_ready),
    .count      (count)
  );

  assign data_in_ready = w_in_ready;
  assign overflow      = r_overflow;

  // Sticky until reset; whether the refused byte is retried is up to the sender.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (data_in_valid && !w_in_ready) begin
      r_overflow <= 1'b1;
    end
  end

endmodule
